// File: rtl/bp_wormhole_link_arbiter.sv
// Packet-granular round-robin arbiter: merges several ready-and wormhole flit
// streams onto one link and holds the grant until the whole packet has been sent.
module bp_wormhole_link_arbiter #(
  parameter int flit_width_p = 16,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0,
  parameter int els_p        = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [els_p*flit_width_p-1:0] data_i,
  input  logic [els_p-1:0]              v_i,
  output logic [els_p-1:0]              ready_and_o,
  output logic [flit_width_p-1:0]       data_o,
  output logic                          v_o,
  input  logic                          ready_and_i,
  output logic [els_p-1:0]              grant_o,
  output logic                          locked_o
);
  localparam int ptrWidth = (els_p > 2) ? $clog2(els_p) : 1;

  typedef enum logic {e_idle, e_locked} state_e;

  state_e                  state_q, state_d;
  logic [ptrWidth-1:0]     rrPtr_q, rrPtr_d;
  logic [ptrWidth-1:0]     owner_q, owner_d;
  logic [len_width_p-1:0]  cnt_q, cnt_d;

  logic [flit_width_p-1:0] flits [els_p];
  logic [ptrWidth-1:0]     scanSel, curSel;
  logic                    scanFound, curActive, handshake;
  logic [len_width_p-1:0]  headerLen;

  for (genvar i = 0; i < els_p; i++) begin : g_unpack
    assign flits[i] = data_i[i*flit_width_p +: flit_width_p];
  end

  function automatic logic [ptrWidth-1:0] wrapInc(input logic [ptrWidth-1:0] p);
    return (p == ptrWidth'(els_p - 1)) ? '0 : p + ptrWidth'(1);
  endfunction

  // Walk from lowest to highest priority so the last hit (closest to the pointer) wins.
  always_comb begin
    scanSel   = '0;
    scanFound = 1'b0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (v_i[ptrWidth'((int'(rrPtr_q) + k) % els_p)]) begin
        scanSel   = ptrWidth'((int'(rrPtr_q) + k) % els_p);
        scanFound = 1'b1;
      end
    end
  end

  always_comb begin
    curSel    = scanSel;
    curActive = scanFound;
    if (state_q == e_locked) begin
      curSel    = owner_q;
      curActive = 1'b1;
    end
  end

  assign data_o    = flits[curSel];
  assign v_o       = (state_q == e_locked) ? v_i[owner_q] : scanFound;
  assign handshake = v_o & ready_and_i;
  assign headerLen = data_o[len_offset_p +: len_width_p];
  assign locked_o  = (state_q == e_locked);

  always_comb begin
    grant_o     = '0;
    ready_and_o = '0;
    for (int i = 0; i < els_p; i++) begin
      grant_o[i]     = curActive && (curSel == ptrWidth'(i));
      ready_and_o[i] = grant_o[i] & ready_and_i;
    end
  end

  // The pointer only advances when a packet finishes, never on a displaced header.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_idle: begin
        if (handshake) begin
          if (headerLen == '0) begin
            rrPtr_d = wrapInc(scanSel);
          end else begin
            owner_d = scanSel;
            cnt_d   = headerLen;
            state_d = e_locked;
          end
        end
      end
      e_locked: begin
        if (handshake) begin
          cnt_d = cnt_q - len_width_p'(1);
          if (cnt_q == len_width_p'(1)) begin
            state_d = e_idle;
            rrPtr_d = wrapInc(owner_q);
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      rrPtr_q <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_wormhole_link_arbiter.sv
// Directed bench for bp_wormhole_link_arbiter: a 2-requester and a 4-requester
// instance, each scenario checks the merged outputs cycle by cycle.
module tb_bp_wormhole_link_arbiter;
  logic clock;
  logic reset;

  logic [1:0]  v2, rdyOut2, grant2;
  logic [31:0] data2;
  logic [15:0] dataOut2;
  logic        rdyIn2, vOut2, locked2;

  logic [3:0]  v4, rdyOut4, grant4;
  logic [63:0] data4;
  logic [15:0] dataOut4;
  logic        rdyIn4, vOut4, locked4;

  logic [21:0] obs2, exp2;
  logic [25:0] obs4, exp4;
  int total = 0;
  int bad = 0;

  assign obs2 = {vOut2, locked2, grant2, rdyOut2, dataOut2};
  assign obs4 = {vOut4, locked4, grant4, rdyOut4, dataOut4};

  bp_wormhole_link_arbiter #(
    .flit_width_p(16), .len_width_p(3), .len_offset_p(8), .els_p(2)
  ) dut2 (
    .clk_i(clock), .reset_i(reset), .data_i(data2), .v_i(v2),
    .ready_and_o(rdyOut2), .data_o(dataOut2), .v_o(vOut2),
    .ready_and_i(rdyIn2), .grant_o(grant2), .locked_o(locked2)
  );

  bp_wormhole_link_arbiter #(
    .flit_width_p(16), .len_width_p(3), .len_offset_p(8), .els_p(4)
  ) dut4 (
    .clk_i(clock), .reset_i(reset), .data_i(data4), .v_i(v4),
    .ready_and_o(rdyOut4), .data_o(dataOut4), .v_o(vOut4),
    .ready_and_i(rdyIn4), .grant_o(grant4), .locked_o(locked4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flit layout used by the bench: [10:8] length, [7:0] tag.
  function automatic logic [15:0] mk(input logic [7:0] tag, input logic [2:0] len);
    return {5'b0, len, tag};
  endfunction

  task automatic applyStimulus2(input logic [1:0] v, input logic [15:0] d1,
                                input logic [15:0] d0, input logic r);
    v2 = v; data2 = {d1, d0}; rdyIn2 = r;
    #1;
  endtask

  task automatic applyStimulus4(input logic [3:0] v, input logic [15:0] d3,
                                input logic [15:0] d2, input logic [15:0] d1,
                                input logic [15:0] d0, input logic r);
    v4 = v; data4 = {d3, d2, d1, d0}; rdyIn4 = r;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    applyStimulus2(2'b00, 16'h0, 16'h0, 1'b1);
    applyStimulus4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if ({vOut2, locked2, grant2, rdyOut2} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset2: got %b want %b", {vOut2, locked2, grant2, rdyOut2}, 6'b0);
    end
    total++;
    if ({vOut4, locked4, grant4, rdyOut4} !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset4: got %b want %b", {vOut4, locked4, grant4, rdyOut4}, 10'b0);
    end
    @(negedge clock);
    applyStimulus2(2'b11, mk(8'hB0, 3'd0), mk(8'hA0, 3'd0), 1'b0);
    exp2 = {1'b1, 1'b0, 2'b01, 2'b00, mk(8'hA0, 3'd0)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL reset_ptr2: got %h want %h", obs2, exp2);
    end
    applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b0);
    exp4 = {1'b1, 1'b0, 4'b0001, 4'b0000, mk(8'h40, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL reset_ptr4: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
  endtask

  task automatic test_no_interleave;
    applyStimulus2(2'b11, mk(8'hB0, 3'd0), mk(8'hA0, 3'd3), 1'b1);
    exp2 = {1'b1, 1'b0, 2'b01, 2'b01, mk(8'hA0, 3'd3)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL ni_header: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus2(2'b11, mk(8'hB0, 3'd0), mk(8'(8'hA0 + k), 3'd5), 1'b1);
      exp2 = {1'b1, 1'b1, 2'b01, 2'b01, mk(8'(8'hA0 + k), 3'd5)};
      total++;
      if (obs2 !== exp2) begin
        bad++;
        $display("[TB] FAIL ni_body%0d: got %h want %h", k, obs2, exp2);
      end
      @(negedge clock);
    end
    applyStimulus2(2'b11, mk(8'hB0, 3'd0), mk(8'hA4, 3'd0), 1'b1);
    exp2 = {1'b1, 1'b0, 2'b10, 2'b10, mk(8'hB0, 3'd0)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL ni_req1_next: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
    applyStimulus2(2'b11, mk(8'hB0, 3'd0), mk(8'hA4, 3'd0), 1'b1);
    exp2 = {1'b1, 1'b0, 2'b01, 2'b01, mk(8'hA4, 3'd0)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL ni_req0_again: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    applyStimulus2(2'b11, mk(8'hC0, 3'd1), mk(8'hD0, 3'd7), 1'b1);
    exp2 = {1'b1, 1'b0, 2'b10, 2'b10, mk(8'hC0, 3'd1)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL b2b_hdr1: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
    applyStimulus2(2'b11, mk(8'hC1, 3'd6), mk(8'hD0, 3'd7), 1'b1);
    exp2 = {1'b1, 1'b1, 2'b10, 2'b10, mk(8'hC1, 3'd6)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL b2b_body1: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
    applyStimulus2(2'b11, mk(8'hC2, 3'd0), mk(8'hD0, 3'd7), 1'b1);
    exp2 = {1'b1, 1'b0, 2'b01, 2'b01, mk(8'hD0, 3'd7)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL b2b_hdr0: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus2(2'b11, mk(8'hC2, 3'd0), mk(8'(8'hD0 + k), 3'd0), 1'b1);
      exp2 = {1'b1, 1'b1, 2'b01, 2'b01, mk(8'(8'hD0 + k), 3'd0)};
      total++;
      if (obs2 !== exp2) begin
        bad++;
        $display("[TB] FAIL b2b_maxlen_body%0d: got %h want %h", k, obs2, exp2);
      end
      @(negedge clock);
    end
    applyStimulus2(2'b11, mk(8'hC2, 3'd0), mk(8'hD8, 3'd0), 1'b0);
    exp2 = {1'b1, 1'b0, 2'b10, 2'b00, mk(8'hC2, 3'd0)};
    total++;
    if (obs2 !== exp2) begin
      bad++;
      $display("[TB] FAIL b2b_after: got %h want %h", obs2, exp2);
    end
    @(negedge clock);
  endtask

  task automatic test_round_robin;
    for (int k = 0; k < 5; k++) begin
      applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b1);
      exp4 = {1'b1, 1'b0, 4'(4'b0001 << (k % 4)), 4'(4'b0001 << (k % 4)), mk(8'(8'h40 + (k % 4)), 3'd0)};
      total++;
      if (obs4 !== exp4) begin
        bad++;
        $display("[TB] FAIL rr_grant%0d: got %h want %h", k, obs4, exp4);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_bubble;
    applyStimulus4(4'b0100, mk(8'h43, 3'd0), mk(8'h20, 3'd2), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b1);
    exp4 = {1'b1, 1'b0, 4'b0100, 4'b0100, mk(8'h20, 3'd2)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL bub_header: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      applyStimulus4(4'b1011, mk(8'h43, 3'd0), mk(8'h21, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b1);
      exp4 = {1'b0, 1'b1, 4'b0100, 4'b0100, mk(8'h21, 3'd0)};
      total++;
      if (obs4 !== exp4) begin
        bad++;
        $display("[TB] FAIL bub_gap%0d: got %h want %h", k, obs4, exp4);
      end
      @(negedge clock);
    end
    for (int k = 1; k <= 2; k++) begin
      applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'(8'h20 + k), 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b1);
      exp4 = {1'b1, 1'b1, 4'b0100, 4'b0100, mk(8'(8'h20 + k), 3'd0)};
      total++;
      if (obs4 !== exp4) begin
        bad++;
        $display("[TB] FAIL bub_body%0d: got %h want %h", k, obs4, exp4);
      end
      @(negedge clock);
    end
    applyStimulus4(4'b1011, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b0);
    exp4 = {1'b1, 1'b0, 4'b1000, 4'b0000, mk(8'h43, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL bub_next_ptr: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
  endtask

  task automatic test_stall;
    applyStimulus4(4'b0010, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h10, 3'd3), mk(8'h40, 3'd0), 1'b1);
    exp4 = {1'b1, 1'b0, 4'b0010, 4'b0010, mk(8'h10, 3'd3)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL stall_header: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    applyStimulus4(4'b0010, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h11, 3'd0), mk(8'h40, 3'd0), 1'b1);
    exp4 = {1'b1, 1'b1, 4'b0010, 4'b0010, mk(8'h11, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL stall_body1: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h12, 3'd0), mk(8'h40, 3'd0), 1'b0);
      exp4 = {1'b1, 1'b1, 4'b0010, 4'b0000, mk(8'h12, 3'd0)};
      total++;
      if (obs4 !== exp4) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d: got %h want %h", k, obs4, exp4);
      end
      @(negedge clock);
    end
    for (int k = 2; k <= 3; k++) begin
      applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'(8'h10 + k), 3'd0), mk(8'h40, 3'd0), 1'b1);
      exp4 = {1'b1, 1'b1, 4'b0010, 4'b0010, mk(8'(8'h10 + k), 3'd0)};
      total++;
      if (obs4 !== exp4) begin
        bad++;
        $display("[TB] FAIL stall_release%0d: got %h want %h", k, obs4, exp4);
      end
      @(negedge clock);
    end
    applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b0);
    exp4 = {1'b1, 1'b0, 4'b0100, 4'b0000, mk(8'h42, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL stall_done_ptr: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_packet;
    applyStimulus4(4'b0001, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h30, 3'd3), 1'b1);
    exp4 = {1'b1, 1'b0, 4'b0001, 4'b0001, mk(8'h30, 3'd3)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL rm_header: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    applyStimulus4(4'b0001, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h31, 3'd0), 1'b1);
    exp4 = {1'b1, 1'b1, 4'b0001, 4'b0001, mk(8'h31, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL rm_body1: got %h want %h", obs4, exp4);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b0);
    exp4 = {1'b1, 1'b0, 4'b0001, 4'b0000, mk(8'h40, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL rm_after_reset: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    applyStimulus4(4'b0010, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h55, 3'd0), mk(8'h40, 3'd0), 1'b1);
    exp4 = {1'b1, 1'b0, 4'b0010, 4'b0010, mk(8'h55, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL rm_fresh_header: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
    applyStimulus4(4'b1111, mk(8'h43, 3'd0), mk(8'h42, 3'd0), mk(8'h41, 3'd0), mk(8'h40, 3'd0), 1'b0);
    exp4 = {1'b1, 1'b0, 4'b0100, 4'b0000, mk(8'h42, 3'd0)};
    total++;
    if (obs4 !== exp4) begin
      bad++;
      $display("[TB] FAIL rm_fresh_accepted: got %h want %h", obs4, exp4);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    v2 = '0; data2 = '0; rdyIn2 = 1'b0;
    v4 = '0; data4 = '0; rdyIn4 = 1'b0;
    @(negedge clock);
    test_reset();
    test_no_interleave();
    test_back_to_back();
    test_round_robin();
    test_bubble();
    test_stall();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
